mem_store_ctrl: RTL and testbench

MEM_STORE_CTRL -- requirements
Module: mem_store_ctrl

---
 rtl/mem_store_ctrl.sv | 130 +++++++++++++
 tb/tb_mem_store_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_store_ctrl.sv
// mem_store_ctrl: debounces two pushbuttons and drives a 4-byte memory (byte store or clear-all).
// Latency: a press drives store ~DB_CYCLES+3 clk after the raw edge; WRITE is 1 cycle, CLEAR is 4 cycles.
// Backpressure: none; presses arriving while busy are dropped, and busy holds until both buttons release.
// Ports: clk/rst_n (async active-low); btn_store/btn_clear raw buttons; sw_data/sw_addr switches;
//        data/addr/store to the memory; busy status; wr_count counts store strobes modulo 256.
module mem_store_ctrl #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_store,
  input  logic       btn_clear,
  input  logic [7:0] sw_data,
  input  logic [1:0] sw_addr,
  output logic [7:0] data,
  output logic [1:0] addr,
  output logic       store,
  output logic       busy,
  output logic [7:0] wr_count
);

  localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, WRITE, CLEAR, WAIT_REL} state_t;

  state_t          state, state_nxt;
  logic [1:0]      btn_raw;
  logic [1:0]      sync1, sync2;
  logic [1:0]      db, db_d;
  logic [CW-1:0]   db_cnt [2];
  logic [1:0]      press;
  logic [1:0]      waddr;
  logic [1:0]      clr_idx;
  logic [7:0]      data_q;

  // Bit 0 is the store button, bit 1 the clear button.
  assign btn_raw = {btn_clear, btn_store};

  // Synchronizers and debouncers. The debounced level only moves after the
  // synchronized level has disagreed with it for DB_CYCLES consecutive cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      db_d  <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      db_d  <= db;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != db[i]) begin
          if (db_cnt[i] == CW'(DB_CYCLES - 1)) begin
            db[i]     <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + CW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // Rising edge of the debounced level. db_d resets to 0, so a button held
  // through reset still yields a press once it debounces high.
  assign press = db & ~db_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    store     = 1'b0;
    busy      = 1'b1;
    addr      = sw_addr;
    case (state)
      IDLE: begin
        busy = 1'b0;
        // Clear takes priority; a simultaneous store press is dropped.
        if (press[1])      state_nxt = CLEAR;
        else if (press[0]) state_nxt = WRITE;
      end
      WRITE: begin
        store     = 1'b1;
        addr      = waddr;
        state_nxt = WAIT_REL;
      end
      CLEAR: begin
        store = 1'b1;
        addr  = clr_idx;
        if (clr_idx == 2'd3) state_nxt = WAIT_REL;
      end
      WAIT_REL: begin
        if (db == 2'b00) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: data register doubles as the clear pattern, so it keeps 0x00
  // after a clear until the next store capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q   <= '0;
      waddr    <= '0;
      clr_idx  <= '0;
      wr_count <= '0;
    end else begin
      wr_count <= wr_count + {7'd0, store};
      if (state == IDLE) begin
        if (press[1]) begin
          clr_idx <= '0;
          data_q  <= '0;
        end else if (press[0]) begin
          data_q <= sw_data;
          waddr  <= sw_addr;
        end
      end
      if (state == CLEAR) clr_idx <= clr_idx + 2'd1;
    end
  end

  assign data = data_q;

endmodule

// File: tb/tb_mem_store_ctrl.sv
// tb_mem_store_ctrl: randomized button/switch stimulus against a transaction-level model of mem_store_ctrl.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_mem_store_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_store = 1'b0;
  logic       btn_clear = 1'b0;
  logic [7:0] sw_data = 8'h00;
  logic [1:0] sw_addr = 2'd0;
  logic [7:0] data;
  logic [1:0] addr;
  logic       store;
  logic       busy;
  logic [7:0] wr_count;

  mem_store_ctrl #(.DB_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .btn_store(btn_store), .btn_clear(btn_clear),
    .sw_data(sw_data), .sw_addr(sw_addr), .data(data), .addr(addr),
    .store(store), .busy(busy), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] a;
    logic [7:0] d;
  } st_t;

  st_t        obs_q[$];
  st_t        exp_q[$];
  int         run_len = 0;
  int         max_run = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  logic [7:0] exp_cnt = 8'd0;
  logic [7:0] exp_data = 8'd0;

  // Record every memory write the DUT issues, plus the longest store burst.
  always @(negedge clk) begin
    if (store) begin
      obs_q.push_back({addr, data});
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [1:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
    exp_cnt  = exp_cnt + 8'd1;
    exp_data = d;
  endtask

  task automatic push_clear();
    for (int i = 0; i < 4; i++) push_exp(2'(i), 8'h00);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 60) begin
      tick(1);
      k++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic cmp_stores();
    int n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    chk("n_stores", obs_q.size(), exp_q.size());
    for (int i = 0; i < n; i++) begin
      chk("st_addr", {30'd0, obs_q[i].a}, {30'd0, exp_q[i].a});
      chk("st_data", {24'd0, obs_q[i].d}, {24'd0, exp_q[i].d});
    end
    chk("wr_count", {24'd0, wr_count}, {24'd0, exp_cnt});
    chk("store_run_le4", {31'd0, (max_run <= 4)}, 32'd1);
    obs_q.delete();
    exp_q.delete();
    max_run = 0;
  endtask

  // kind: 0 store, 1 glitch, 2 clear, 3 both together, 4 clear pressed during release wait
  task automatic do_op(input int kind);
    logic [7:0] d = 8'($urandom);
    logic [1:0] a = 2'($urandom_range(0, 3));
    int hold = $urandom_range(8, 16);
    sw_data = d;
    sw_addr = a;
    case (kind)
      0: begin
        btn_store = 1'b1;
        tick(hold);
        chk("busy_held", {31'd0, busy}, 32'd1);
        btn_store = 1'b0;
        tick(3);
        chk("busy_releasing", {31'd0, busy}, 32'd1);
        push_exp(a, d);
      end
      1: begin
        btn_store = 1'b1;
        tick($urandom_range(1, 3));
        btn_store = 1'b0;
        tick(10);
        chk("glitch_busy", {31'd0, busy}, 32'd0);
      end
      2, 3: begin
        btn_clear = 1'b1;
        if (kind == 3) btn_store = 1'b1;
        tick(hold);
        chk("busy_held", {31'd0, busy}, 32'd1);
        btn_clear = 1'b0;
        btn_store = 1'b0;
        push_clear();
      end
      default: begin
        btn_store = 1'b1;
        tick(hold);
        btn_clear = 1'b1;
        tick(8);
        chk("busy_both_held", {31'd0, busy}, 32'd1);
        btn_store = 1'b0;
        btn_clear = 1'b0;
        push_exp(a, d);
      end
    endcase
    wait_idle();
    tick(2);
    sw_data = 8'($urandom);
    #1;
    chk("data_hold", {24'd0, data}, {24'd0, exp_data});
    chk("addr_follow", {30'd0, addr}, {30'd0, sw_addr});
    cmp_stores();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_store"}, {31'd0, store}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_data"}, {24'd0, data}, 32'd0);
    chk({tag, "_wr_count"}, {24'd0, wr_count}, 32'd0);
    chk({tag, "_addr"}, {30'd0, addr}, {30'd0, sw_addr});
  endtask

  initial begin
    bit found;
    sw_data = 8'h3C;
    sw_addr = 2'd1;
    tick(3);
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    tick(2);

    // Directed case 1: 0xA5 to address 2.
    sw_data   = 8'hA5;
    sw_addr   = 2'd2;
    btn_store = 1'b1;
    tick(12);
    chk("c1_busy", {31'd0, busy}, 32'd1);
    btn_store = 1'b0;
    push_exp(2'd2, 8'hA5);
    wait_idle();
    cmp_stores();

    for (int i = 0; i < 40; i++) do_op($urandom_range(0, 4));
    do_op(3);
    do_op(1);

    // Reset asserted during the third clear cycle.
    btn_clear = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 80 && !found; k++) begin
      @(negedge clk);
      if (store && addr == 2'd2) found = 1'b1;
    end
    chk("clr3_seen", {31'd0, found}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_store", {31'd0, store}, 32'd0);
    btn_clear = 1'b0;
    tick(3);
    chk_reset_outputs("midrst");
    rst_n = 1'b1;
    tick(2);
    chk_reset_outputs("postrst");
    for (int i = 0; i < 3; i++) push_exp(2'(i), 8'h00);
    exp_cnt  = 8'd0;
    exp_data = 8'd0;
    cmp_stores();

    // 256 stores from zero wrap the counter.
    for (int i = 0; i < 256; i++) do_op(0);
    chk("wrap_zero", {24'd0, wr_count}, 32'd0);

    // addr follows the switches in IDLE with no strobe.
    for (int a = 0; a < 4; a++) begin
      sw_addr = 2'(a);
      #1;
      chk("sweep_addr", {30'd0, addr}, a);
      chk("sweep_store", {31'd0, store}, 32'd0);
    end

    // Button held through reset release still produces one store.
    sw_data   = 8'h5A;
    sw_addr   = 2'd3;
    btn_store = 1'b1;
    tick(2);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    exp_cnt  = 8'd0;
    obs_q.delete();
    max_run = 0;
    tick(12);
    chk("held_busy", {31'd0, busy}, 32'd1);
    btn_store = 1'b0;
    push_exp(2'd3, 8'h5A);
    wait_idle();
    cmp_stores();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
